// File: rtl/breadboard_sweep.sv
// Sweeps the four breadboard inputs through all 16 combinations, captures the
// ten outputs per vector into a truth table and folds them into a rotating signature.
module breadboard_sweep #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    input  logic [9:0]  f,
    output logic        busy,
    output logic        done,
    output logic [15:0] sig,
    input  logic [3:0]  rd_addr,
    output logic [9:0]  rd_data
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [3:0]  vec_reg;
    logic [3:0]  drive_reg;
    logic [7:0]  cnt_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] sig_reg;
    logic [9:0]  rd_data_reg;
    logic [9:0]  mem [16];
    logic        capture;

    assign capture      = (state_reg == RUN) && (cnt_reg == SETTLE_C);
    assign {w, x, y, z} = drive_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign sig          = sig_reg;
    assign rd_data      = rd_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            vec_reg   <= 4'd0;
            drive_reg <= 4'd0;
            cnt_reg   <= 8'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sig_reg   <= 16'd0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        vec_reg   <= 4'd0;
                        drive_reg <= 4'd0;
                        cnt_reg   <= 8'd0;
                        sig_reg   <= 16'd0;
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!capture) begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end else begin
                        sig_reg <= {sig_reg[14:0], sig_reg[15]} ^ {6'b0, f};
                        if (vec_reg == 4'd15) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            drive_reg <= 4'd0;
                            state_reg <= DONE;
                        end else begin
                            // drive tracks vec so the new vector is on the pins the cycle after capture
                            vec_reg   <= vec_reg + 4'd1;
                            drive_reg <= vec_reg + 4'd1;
                            cnt_reg   <= 8'd0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-entry registers so rst can clear the whole table in one cycle.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst)
                    mem[gi] <= 10'd0;
                else if (capture && (vec_reg == 4'(gi)))
                    mem[gi] <= f;
            end
        end
    endgenerate

    // Read sees the pre-capture contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data_reg <= 10'd0;
        else
            rd_data_reg <= mem[rd_addr];
    end

endmodule

// File: tb/tb_breadboard_sweep.sv
// Directed bench: one sweeper with SETTLE=2 (identity / inverted models) and
// one with SETTLE=0 (one-hot decoder model).
module tb_breadboard_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2, start0;
    logic        w2, x2, y2, z2, w0, x0, y0, z0;
    logic [9:0]  f2, f0;
    logic        busy2, done2, busy0, done0;
    logic [15:0] sig2, sig0;
    logic [3:0]  rd_addr2, rd_addr0;
    logic [9:0]  rd_data2, rd_data0;
    logic        inv_mode;
    int          errors = 0;
    int          checks = 0;
    int          n;

    always #5 clk = ~clk;

    // Breadboard models: identity or inverted index for u_s2, one-hot decoder for u_s0.
    assign f2 = inv_mode ? ~{6'b0, w2, x2, y2, z2} : {6'b0, w2, x2, y2, z2};
    assign f0 = ({w0, x0, y0, z0} < 4'd10) ? (10'd1 << {w0, x0, y0, z0}) : 10'd0;

    breadboard_sweep #(.SETTLE(2)) u_s2 (
        .clk(clk), .rst(rst), .start(start2),
        .w(w2), .x(x2), .y(y2), .z(z2), .f(f2),
        .busy(busy2), .done(done2), .sig(sig2),
        .rd_addr(rd_addr2), .rd_data(rd_data2)
    );

    breadboard_sweep #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start0),
        .w(w0), .x(x0), .y(y0), .z(z0), .f(f0),
        .busy(busy0), .done(done0), .sig(sig0),
        .rd_addr(rd_addr0), .rd_data(rd_data0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read2(input logic [3:0] a, input logic [9:0] exp);
        rd_addr2 = a;
        tick();
        check($sformatf("rd2[%0d]", a), 32'(rd_data2), 32'(exp));
    endtask

    // Starts a SETTLE=2 sweep; n counts samples with busy high after the accepting edge.
    // inj_n re-pulses start mid-run, abort_n asserts rst, col checks the addr-4 collision.
    task automatic sweep2(input int inj_n, input int abort_n, input bit col, output int cnt);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("acc_busy", 32'(busy2), 32'd1);
        check("acc_done", 32'(done2), 32'd0);
        check("acc_sig", 32'(sig2), 32'd0);
        cnt = 0;
        while (busy2 && cnt < 200) begin
            if (col && cnt == 15) check("col_old", 32'(rd_data2), 32'h004);
            if (col && cnt == 16) check("col_new", 32'(rd_data2), 32'h3FB);
            if (cnt == abort_n) begin
                check("pre_abort_sig", 32'(sig2), 32'h0004);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                return;
            end
            start2 = (cnt == inj_n);
            tick();
            start2 = 1'b0;
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; start2 = 1'b1; start0 = 1'b1;
        rd_addr2 = 4'd0; rd_addr0 = 4'd0; inv_mode = 1'b0;
        tick();
        tick();
        rst = 1'b0; start2 = 1'b0; start0 = 1'b0;
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_done2", 32'(done2), 32'd0);
        check("rst_sig2", 32'(sig2), 32'd0);
        check("rst_wxyz2", 32'({w2, x2, y2, z2}), 32'd0);
        check("rst_rd2", 32'(rd_data2), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_sig0", 32'(sig0), 32'd0);
        for (int a = 0; a < 16; a++) read2(4'(a), 10'd0);

        // Identity sweep
        sweep2(-1, -1, 1'b0, n);
        check("id_len", 32'(n), 32'd48);
        check("id_done", 32'(done2), 32'd1);
        check("id_sig", 32'(sig2), 32'h08F7);
        check("id_wxyz", 32'({w2, x2, y2, z2}), 32'd0);
        for (int a = 0; a < 16; a++) read2(4'(a), 10'(a));

        // Start re-pulsed while vector 5 is on the pins must be ignored
        sweep2(16, -1, 1'b0, n);
        check("ign_len", 32'(n), 32'd48);
        check("ign_done", 32'(done2), 32'd1);
        check("ign_sig", 32'(sig2), 32'h08F7);

        // Restart from DONE with inverted model, watching the addr-4 collision
        inv_mode = 1'b1;
        rd_addr2 = 4'd4;
        sweep2(-1, -1, 1'b1, n);
        check("inv_len", 32'(n), 32'd48);
        read2(4'd4, 10'h3FB);
        read2(4'd9, 10'h3F6);
        inv_mode = 1'b0;

        // One-hot decoder with SETTLE=0
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (busy0 && n < 200) begin
            tick();
            n++;
        end
        check("oh_len", 32'(n), 32'd16);
        check("oh_done", 32'(done0), 32'd1);
        check("oh_sig", 32'(sig0), 32'h0000);
        rd_addr0 = 4'd3;  tick(); check("oh_rd3", 32'(rd_data0), 32'h008);
        rd_addr0 = 4'd9;  tick(); check("oh_rd9", 32'(rd_data0), 32'h200);
        rd_addr0 = 4'd12; tick(); check("oh_rd12", 32'(rd_data0), 32'h000);

        // Abort at vector 7
        sweep2(-1, 22, 1'b0, n);
        check("ab_busy", 32'(busy2), 32'd0);
        check("ab_done", 32'(done2), 32'd0);
        check("ab_wxyz", 32'({w2, x2, y2, z2}), 32'd0);
        check("ab_sig", 32'(sig2), 32'd0);
        check("ab_rd", 32'(rd_data2), 32'd0);
        read2(4'd0, 10'd0);
        read2(4'd4, 10'd0);
        read2(4'd6, 10'd0);
        read2(4'd15, 10'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/breadboard_sweep.md
# breadboard_sweep

Sequencer and capture stage wrapped around the combinational breadboard function block. It drives the block's four inputs w, x, y, z through all 16 input combinations and samples the ten outputs f0..f9 for each combination. Results go into a 16-entry truth-table memory, and a running 16-bit signature is kept alongside. Lab tooling or a checker reads back the captured table through a registered read port and compares the signature against a golden value.

## Interface
- SETTLE, default 2: idle cycles between applying a vector and sampling f; range 0..255.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a sweep.
- w, x, y, z  out  1 each  inputs to the breadboard block; w is the MSB of the vector index.
- f  in  10  breadboard outputs; f[0]=f0 … f[9]=f9.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high after a sweep completes; held until the next accepted start or rst.
- sig  out  16  running signature.
- rd_addr  in  4  truth-table read address (vector index).
- rd_data  out  10  captured f for rd_addr.

## Operation
- States: IDLE, RUN, DONE. Internal registers:
  - vec[3:0] is the vector index.
  - cnt[7:0] is the settle counter.
  - mem holds 16×10 captured values.
- Reset value of every output and register is 0: w, x, y, z, busy, done, sig, rd_data, vec, cnt and all mem entries. State goes to IDLE.
- Start acceptance:
  - start is accepted in IDLE or DONE.
  - On acceptance: vec←0, cnt←0, sig←0, done←0, busy←1, state→RUN.
  - mem is not cleared by start.
  - start is ignored in RUN.
- Vector drive: {w,x,y,z} is a registered copy of vec, driven only while in RUN. It returns to 0000 when the sweep ends.
- Each clock in RUN:
  - If cnt≠SETTLE: cnt←cnt+1.
  - If cnt==SETTLE (capture cycle):
    - mem[vec]←f.
    - sig←{sig[14:0],sig[15]} ^ {6'b0,f}.
    - If vec==15: busy←0, done←1, state→DONE, {w,x,y,z}←0000.
    - Otherwise: vec←vec+1 and cnt←0.
- Vector order is strictly 0..15 with no wrap; a sweep never restarts on its own.
- Read port:
  - rd_data←mem[rd_addr] every cycle, in all states.
  - A read during RUN returns the current contents, which may be from the previous sweep for entries not yet captured.
  - A capture and a read of the same address in the same cycle return the old value; the new value is visible on the next read.
- rst during RUN aborts immediately. All state returns to the reset values, including mem.

## Timing
- start accepted at edge k:
  - busy=1 from k+1.
  - The RUN clock that captures vector 0 is the one at edge k+SETTLE+1; vector 0 is visible on w..z from k+1 until then.
- Each vector occupies SETTLE+1 cycles. A full sweep is 16·(SETTLE+1) cycles, from the first busy cycle to done=1 inclusive of the final capture edge.
- f is sampled at the capture edge. The value f carries just before that edge is the one stored.
- SETTLE=0: one cycle per vector. f is captured at the edge that follows the cycle in which the vector was driven.
- Read latency is 1 cycle: rd_data reflects rd_addr presented at the previous edge.
- done and busy are never high together. start in the same cycle as rst: rst wins.

## Test plan
- Reset: assert rst for 2 cycles with start=1 -> all outputs 0, busy=0, done=0, rd_data=0 for all 16 addresses.
- Identity model f={6'b0,w,x,y,z}, SETTLE=2, pulse start:
  - busy high for exactly 48 cycles, then done=1.
  - sig=0x08F7.
  - Reading addresses 0..15 returns 0..15.
- One-hot decoder model (f = 1<<i for i<10, else 0), SETTLE=0:
  - sweep takes 16 cycles; sig=0x0000.
  - mem[3]=0x008, mem[9]=0x200, mem[12]=0x000.
- Ignored start:
  - during RUN, pulse start at vector 5 -> sweep continues and completes at the original 48-cycle point.
  - a second start in DONE -> done drops, a new sweep runs with sig cleared.
- Abort: rst at vector 7 with SETTLE=2 -> next cycle busy=0, done=0, w..z=0000, sig=0, rd_data from any address=0.
- Read collision: at vector 4's capture edge, hold rd_addr=4 -> rd_data shows the old entry, then the new f value on the following cycle.
